// File: rtl/instruc_mem_loader_if.sv
// Byte-stream / instruction-memory write-port bundle for the image loader.
// master: drives byte_in, byte_valid, start; observes the write port and status.
// slave:  the loader; consumes the byte stream and drives mem_we/mem_addr/mem_din, cpu_hold, load_done, load_error.
interface instruc_mem_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              start;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic              cpu_hold;
    logic              load_done;
    logic              load_error;

    modport master (
        output byte_in, byte_valid, start,
        input  mem_we, mem_addr, mem_din, cpu_hold, load_done, load_error
    );

    modport slave (
        input  byte_in, byte_valid, start,
        output mem_we, mem_addr, mem_din, cpu_hold, load_done, load_error
    );
endinterface

// File: rtl/instruc_mem_loader.sv
// Instruction memory loader: 16-bit word count N (MSB first), then N big-endian words written to addresses 0..N-1.
// Ports: clock, reset (async, active-high); bus.slave carries the byte stream in and the memory write port / CPU hold / status out.
// Latency: 4th byte of a word at cycle t -> mem_we at t+1; no backpressure, a byte arriving during a write cycle is still accepted.
module instruc_mem_loader #(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    instruc_mem_loader_if.slave   bus
);
    localparam logic [2:0] S_LEN_HI = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    localparam int              TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit              TMR_EN   = (TIMEOUT_CYC > 0);
    localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT_CYC > 0) ? TMR_W'(TIMEOUT_CYC - 1) : '0;
    // Largest legal word count; 17 bits so 2**16 itself is representable.
    localparam logic [16:0]     DEPTH    = 17'(1) << ADDR_W;

    logic [2:0]        state;
    logic [15:0]       len_q;
    logic [31:0]       word_q;
    logic [1:0]        byte_idx;
    logic [ADDR_W:0]   word_cnt;
    logic [TMR_W-1:0]  timer;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_din_q;
    logic              cpu_hold_q;
    logic              load_done_q;
    logic              load_error_q;

    logic [31:0] word_next;
    logic [16:0] len_next;
    logic        timed_out;

    assign word_next = {word_q[23:0], bus.byte_in};
    assign len_next  = {1'b0, len_q[15:8], bus.byte_in};
    // Fires on the idle cycle that would bring the timer to TIMEOUT_CYC.
    assign timed_out = TMR_EN && !bus.byte_valid && (timer == TMR_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_LEN_HI;
            len_q        <= '0;
            word_q       <= '0;
            byte_idx     <= '0;
            word_cnt     <= '0;
            timer        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state)
                S_LEN_HI: begin
                    if (bus.byte_valid) begin
                        len_q[15:8] <= bus.byte_in;
                        timer       <= '0;
                        state       <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (bus.byte_valid) begin
                        len_q[7:0] <= bus.byte_in;
                        timer      <= '0;
                        word_cnt   <= '0;
                        byte_idx   <= '0;
                        if (len_next == 17'd0) begin
                            state       <= S_DONE;
                            cpu_hold_q  <= 1'b0;
                            load_done_q <= 1'b1;
                        end else if (len_next > DEPTH) begin
                            state        <= S_ERROR;
                            load_error_q <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end else if (timed_out) begin
                        state        <= S_ERROR;
                        load_error_q <= 1'b1;
                    end else if (TMR_EN) begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DATA: begin
                    // word_cnt was bumped with the write, so in the write cycle of
                    // the final word it equals N; the hold is released next cycle.
                    if (mem_we_q && (17'(word_cnt) == {1'b0, len_q})) begin
                        state       <= S_DONE;
                        cpu_hold_q  <= 1'b0;
                        load_done_q <= 1'b1;
                    end else if (bus.byte_valid) begin
                        word_q   <= word_next;
                        byte_idx <= byte_idx + 1'b1;
                        timer    <= '0;
                        if (byte_idx == 2'd3) begin
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= word_cnt[ADDR_W-1:0];
                            mem_din_q  <= word_next;
                            word_cnt   <= word_cnt + 1'b1;
                        end
                    end else if (timed_out) begin
                        state        <= S_ERROR;
                        load_error_q <= 1'b1;
                    end else if (TMR_EN) begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DONE: begin
                    // A byte coinciding with start is dropped: re-arm only.
                    if (bus.start) begin
                        state       <= S_LEN_HI;
                        cpu_hold_q  <= 1'b1;
                        load_done_q <= 1'b0;
                    end
                end
                S_ERROR: begin
                    if (bus.start) begin
                        state        <= S_LEN_HI;
                        load_error_q <= 1'b0;
                    end
                end
                default: state <= S_LEN_HI;
            endcase
        end
    end

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_error = load_error_q;
endmodule
